// File: rtl/rv32m_muldiv_seq.sv
// rv32m_muldiv_seq: iterative RV32M multiply/divide sequencer (32-step shift-add / restoring divide)
module rv32m_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t            state;
  logic [2:0]        f3;
  logic              sign_a, sign_b;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic              sgn_a_op, sgn_b_op, neg_a, neg_b, div_zero, div_ovf, neg;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, quo, rem, final_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_neg, mul_res;
  always_comb begin
    sgn_a_op    = func3[2] ? ~func3[0] : (func3[1:0] != 2'd3);
    sgn_b_op    = func3[2] ? ~func3[0] : ~func3[1];
    neg_a       = sgn_a_op & op_a[XLEN-1];
    neg_b       = sgn_b_op & op_b[XLEN-1];
    abs_a       = neg_a ? -op_a : op_a;
    abs_b       = neg_b ? -op_b : op_b;
    div_zero    = func3[2] & (op_b == '0);
    div_ovf     = func3[2] & ~func3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    special_res = div_zero ? (func3[1] ? op_a : '1) : (func3[1] ? '0 : op_a);
    // multiply: acc = {partial high, multiplier}; divide: acc = {remainder, dividend/quotient}
    mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next    = {mul_sum, acc[XLEN-1:1]};
    div_sh      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff    = div_sh - {1'b0, mcand};
    div_next    = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    neg         = sign_a ^ sign_b;
    acc_neg     = -acc;
    mul_res     = neg ? acc_neg : acc;
    quo         = acc[XLEN-1:0];
    rem         = acc[2*XLEN-1:XLEN];
    final_res   = !f3[2] ? ((f3[1:0] == 2'd0) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN])
                         : f3[1] ? (sign_a ? -rem : rem) : (neg ? -quo : quo);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      f3     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3     <= func3;
          sign_a <= neg_a;
          sign_b <= neg_b;
          cnt    <= 5'd31;
          busy   <= 1'b1;
          mcand  <= func3[2] ? abs_b : abs_a;
          acc    <= {{XLEN{1'b0}}, func3[2] ? abs_a : abs_b};
          if (div_zero | div_ovf) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= special_res;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= f3[2] ? div_next : mul_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= SIGN;
        end
        SIGN: begin
          result <= final_res;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// tb_rv32m_muldiv_seq: directed vectors, flush/back-to-back/reset sequences, random ops vs arithmetic model
module tb_rv32m_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = '0;

  rv32m_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    if (f == 3'd0 || f == 3'd1) p = sa * sb;
    else if (f == 3'd2) p = sa * $signed(ub);
    else if (f == 3'd3) p = ua * ub;
    else if (b == 32'd0) p = f[1] ? ua : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (f == 3'd4) p = sa / sb;
    else if (f == 3'd5) p = ua / ub;
    else if (f == 3'd6) p = sa % sb;
    else p = ua % ub;
    return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  // drive an accept on the next rising edge, then scramble the inputs
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    func3 = f;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    func3 = 3'($urandom_range(0, 7));
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic wait_done(input logic [31:0] er, input int el, input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 100);
    chk({nm, "_latency"}, c, el);
    chk({nm, "_result"}, result, er);
    chk({nm, "_busy_at_done"}, {31'b0, busy}, 32'd1);
    last_exp = er;
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
    chk({nm, "_held"}, result, er);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout act=%0t exp=finish", $time);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    tbl[1]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 34};
    tbl[2]  = '{3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 34};
    tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    tbl[4]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    tbl[5]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
    tbl[6]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
    tbl[7]  = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34};
    tbl[8]  = '{3'd7, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 34};
    tbl[9]  = '{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    tbl[10] = '{3'd6, 32'h00000005, 32'h00000000, 32'h00000005, 1};
    tbl[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    tbl[13] = '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    tbl[14] = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1};

    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      issue(tbl[i].f, tbl[i].a, tbl[i].b);
      wait_done(tbl[i].r, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // flush mid-divide, then a fresh multiply on the very next cycle
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("flush_no_done", {31'b0, done}, 32'd0);
      if (c == 10) flush = 1'b1;
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result_kept", result, last_exp);
    issue(3'd0, 32'd3, 32'd4);
    wait_done(32'd12, 34, "after_flush");

    // flush together with start in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_start_idle", {31'b0, busy}, 32'd0);

    // start held high: accepts at 0, 35, 70; reset during the third op
    @(negedge clk);
    start = 1'b1;
    func3 = 3'd0;
    op_a  = 32'd2;
    op_b  = 32'd3;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      chk($sformatf("held_busy_c%0d", c), {31'b0, busy},
          {31'b0, (c <= 34) || (c >= 36 && c <= 69) || (c >= 71)});
      chk($sformatf("held_done_c%0d", c), {31'b0, done}, {31'b0, (c == 34) || (c == 69)});
      if (c == 34 || c == 69) chk($sformatf("held_result_c%0d", c), result, 32'd6);
      if (c == 90) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'b0, busy}, 32'd0);
        chk("async_reset_done", {31'b0, done}, 32'd0);
        chk("async_reset_result", result, 32'd0);
      end
    end
    start = 1'b0;
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] ab[2];
      int          lat;
      f = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: ab[k] = 32'h0;
          1: ab[k] = 32'hFFFFFFFF;
          2: ab[k] = 32'h80000000;
          3: ab[k] = $urandom_range(0, 20);
          default: ab[k] = $urandom;
        endcase
      end
      lat = (f[2] && ab[1] == 32'd0) ||
            ((f == 3'd4 || f == 3'd6) && ab[0] == 32'h80000000 && ab[1] == 32'hFFFFFFFF) ? 1 : 34;
      @(negedge clk);
      issue(f, ab[0], ab[1]);
      wait_done(model(f, ab[0], ab[1]), lat, $sformatf("rand%0d_f%0d_%h_%h", i, f, ab[0], ab[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
